// File: rtl/uart_tx_arbiter_if.sv
// Bus between three byte requesters, the arbiter and a UART transmitter.
// master drives requests, payloads and tx_done; slave is the arbiter.
interface uart_tx_arbiter_if;
  logic [2:0] req;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic       tx_done;
  logic [2:0] ack;
  logic [7:0] out_byte;
  logic       uart_tx_go;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req, byte0, byte1, byte2, tx_done,
    input  ack, out_byte, uart_tx_go, grant_id, busy, timeout_err
  );

  modport slave (
    input  req, byte0, byte1, byte2, tx_done,
    output ack, out_byte, uart_tx_go, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between three requesters.
// Each transfer walks IDLE -> GRANT -> SEND -> DONE, with a SEND timeout.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  last_grant;
  logic [1:0]  sel;
  logic [1:0]  pick;
  logic [15:0] cnt;
  logic        timeout_hit;
  logic [7:0]  sel_byte;

  // Search order starts just after the last winner and wraps.
  function automatic logic [1:0] rr_pick(
    input logic [2:0] r,
    input logic [1:0] last
  );
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    case (last)
      2'd0: begin
        first  = 2'd1;
        second = 2'd2;
        third  = 2'd0;
      end
      2'd1: begin
        first  = 2'd2;
        second = 2'd0;
        third  = 2'd1;
      end
      default: begin
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
      end
    endcase
    if (r[first])
      rr_pick = first;
    else if (r[second])
      rr_pick = second;
    else
      rr_pick = third;
  endfunction

  assign pick = rr_pick(bus.req, last_grant);

  // Payload of the requester picked in IDLE.
  always_comb begin
    sel_byte = bus.byte2;
    case (sel)
      2'd0:    sel_byte = bus.byte0;
      2'd1:    sel_byte = bus.byte1;
      default: sel_byte = bus.byte2;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_next     = state;
    bus.uart_tx_go = 1'b0;
    bus.busy       = 1'b1;
    bus.ack        = 3'b000;
    timeout_hit    = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (|bus.req)
          state_next = GRANT;
      end
      GRANT: begin
        state_next = SEND;
      end
      SEND: begin
        bus.uart_tx_go = 1'b1;
        if (bus.tx_done) begin
          state_next = DONE;
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      default: begin
        bus.ack    = 3'b001 << bus.grant_id;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: selection, latched byte/index, timeout counter, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel             <= 2'd0;
      last_grant      <= 2'd2;
      cnt             <= 16'd0;
      bus.out_byte    <= 8'h00;
      bus.grant_id    <= 2'd0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req)
            sel <= pick;
        end
        GRANT: begin
          bus.out_byte <= sel_byte;
          bus.grant_id <= sel;
          cnt          <= 16'd0;
        end
        SEND: begin
          cnt <= cnt + 16'd1;
          if (timeout_hit)
            bus.timeout_err <= 1'b1;
        end
        default: begin
          last_grant <= bus.grant_id;
        end
      endcase
    end
  end

endmodule
